// File: rtl/ps2_prog_campos.sv
// rtl/ps2_prog_campos.sv - keyboard-driven programming of the hours/minutes/seconds register bank
module ps2_prog_campos #(
  parameter int         TIMEOUT_CYC = 50_000_000,
  parameter logic [7:0] MAX_HORA    = 8'h23,
  parameter logic [7:0] MAX_MINSEG  = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tecla_ok,
  input  logic       es_ctrl,
  input  logic       es_enter,
  input  logic       es_esc,
  input  logic       es_digito,
  input  logic [3:0] digito,
  input  logic       wr_ack,
  output logic       wr_req,
  output logic [1:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [1:0] campo,
  output logic       ocupado,
  output logic       error
);

  typedef enum logic [2:0] {S_IDLE, S_DEC, S_UNI, S_CONF, S_ESCR} state_t;

  // Firing when the counter is about to become TIMEOUT_CYC-1.
  localparam logic [25:0] TO_LAST = 26'(TIMEOUT_CYC - 2);

  state_t      r_state;
  logic [3:0]  r_tens;
  logic [3:0]  r_unis;
  logic [1:0]  r_campo;
  logic [25:0] r_cnt;
  logic        r_wr_req;
  logic [1:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_ocupado;
  logic        r_error;

  state_t      w_nxt;
  logic [3:0]  w_tens;
  logic [3:0]  w_unis;
  logic [1:0]  w_campo;
  logic        w_err;
  logic        w_esc;
  logic        w_ctrl;
  logic        w_ent;
  logic        w_dig;
  logic        w_timeout;
  logic [7:0]  w_val;
  logic [7:0]  w_lim;

  assign w_esc  = tecla_ok & es_esc;
  assign w_ctrl = tecla_ok & ~es_esc & es_ctrl;
  assign w_ent  = tecla_ok & ~es_esc & ~es_ctrl & es_enter;
  assign w_dig  = tecla_ok & ~es_esc & ~es_ctrl & ~es_enter & es_digito;
  assign w_val  = {r_tens, r_unis};
  assign w_lim  = (r_campo == 2'd0) ? MAX_HORA : MAX_MINSEG;
  assign w_timeout = (r_state != S_IDLE) && (r_state != S_ESCR) && !tecla_ok &&
                     (r_cnt == TO_LAST);

  always_comb begin
    w_nxt   = r_state;
    w_tens  = r_tens;
    w_unis  = r_unis;
    w_campo = r_campo;
    w_err   = 1'b0;
    case (r_state)
      S_IDLE: if (w_ctrl) begin
        w_nxt   = S_DEC;
        w_campo = 2'd0;
        w_tens  = 4'd0;
        w_unis  = 4'd0;
      end
      S_DEC: if (w_dig) begin
        w_tens = digito;
        w_nxt  = S_UNI;
      end
      S_UNI: if (w_dig) begin
        w_unis = digito;
        w_nxt  = S_CONF;
      end
      S_CONF: begin
        if (w_ent) begin
          if (w_val <= w_lim) begin
            w_nxt = S_ESCR;
          end else begin
            w_err  = 1'b1;
            w_tens = 4'd0;
            w_unis = 4'd0;
            w_nxt  = S_DEC;
          end
        end else if (w_dig) begin
          w_tens = r_unis;
          w_unis = digito;
        end
      end
      S_ESCR: if (wr_ack) begin
        w_tens = 4'd0;
        w_unis = 4'd0;
        if (r_campo == 2'd2) begin
          w_nxt   = S_IDLE;
          w_campo = 2'd0;
        end else begin
          w_nxt   = S_DEC;
          w_campo = r_campo + 2'd1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    // Esc is honoured everywhere except while a write is outstanding.
    if ((w_esc && r_state != S_IDLE && r_state != S_ESCR) || w_timeout) begin
      w_nxt   = S_IDLE;
      w_campo = 2'd0;
      w_tens  = 4'd0;
      w_unis  = 4'd0;
      w_err   = w_timeout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_tens    <= 4'd0;
      r_unis    <= 4'd0;
      r_campo   <= 2'd0;
      r_cnt     <= 26'd0;
      r_wr_req  <= 1'b0;
      r_wr_addr <= 2'd0;
      r_wr_data <= 8'd0;
      r_ocupado <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_tens    <= w_tens;
      r_unis    <= w_unis;
      r_campo   <= w_campo;
      r_error   <= w_err;
      r_ocupado <= (w_nxt != S_IDLE);
      r_wr_req  <= (w_nxt == S_ESCR);
      if (r_state == S_CONF && w_nxt == S_ESCR) begin
        r_wr_addr <= r_campo;
        r_wr_data <= w_val;
      end
      if (tecla_ok || w_nxt != r_state || r_state == S_IDLE) begin
        r_cnt <= 26'd0;
      end else if (r_state != S_ESCR) begin
        r_cnt <= r_cnt + 26'd1;
      end
    end
  end

  assign wr_req  = r_wr_req;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign campo   = r_campo;
  assign ocupado = r_ocupado;
  assign error   = r_error;

endmodule

// File: tb/tb_ps2_prog_campos.sv
// tb/tb_ps2_prog_campos.sv - scoreboard bench for ps2_prog_campos
module tb_ps2_prog_campos;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tecla_ok = 1'b0, es_ctrl = 1'b0, es_enter = 1'b0, es_esc = 1'b0, es_digito = 1'b0;
  logic [3:0] digito = 4'd0;
  logic       wr_ack = 1'b0;
  logic       wr_req;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] campo;
  logic       ocupado;
  logic       error;

  ps2_prog_campos #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .tecla_ok(tecla_ok), .es_ctrl(es_ctrl), .es_enter(es_enter),
    .es_esc(es_esc), .es_digito(es_digito), .digito(digito), .wr_ack(wr_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .campo(campo),
    .ocupado(ocupado), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a session is a field index plus the last two digits typed.
  logic [9:0] exp_wr[$];
  int         exp_err = 0;
  bit         m_act = 0;
  int         m_field = 0;
  int         m_dig[$];
  bit         m_wr_now = 0;

  function automatic void model_reset();
    m_act = 0;
    m_field = 0;
    m_dig.delete();
  endfunction

  function automatic void model_key(input bit e, input bit c, input bit n, input bit g,
                                    input logic [3:0] d);
    int v;
    int lim;
    m_wr_now = 0;
    if (!m_act) begin
      if (c && !e) begin
        m_act = 1;
        m_field = 0;
        m_dig.delete();
      end
      return;
    end
    if (e) begin
      model_reset();
      return;
    end
    if (c) return;
    if (n) begin
      if (m_dig.size() == 2) begin
        v   = m_dig[0] * 10 + m_dig[1];
        lim = (m_field == 0) ? 23 : 59;
        if (v <= lim) begin
          exp_wr.push_back({2'(m_field), 4'(v / 10), 4'(v % 10)});
          m_wr_now = 1;
          m_dig.delete();
          if (m_field == 2) model_reset();
          else m_field++;
        end else begin
          exp_err++;
          m_dig.delete();
        end
      end
      return;
    end
    if (g) begin
      m_dig.push_back(int'(d));
      if (m_dig.size() > 2) void'(m_dig.pop_front());
    end
  endfunction

  // Arbiter stand-in: either acks permanently or after ack_delay cycles of wr_req.
  bit ack_tied = 1;
  int ack_delay = 1;
  int ack_cnt = 0;
  initial forever begin
    @(posedge clk);
    #2;
    if (ack_tied) begin
      wr_ack = 1'b1;
    end else if (wr_req) begin
      ack_cnt++;
      wr_ack = (ack_cnt == ack_delay);
    end else begin
      ack_cnt = 0;
      wr_ack = 1'b0;
    end
  end

  // Monitor: pops expected writes/errors as the DUT presents them.
  logic       p_req = 0, p_ack = 0, p_err = 0;
  logic [9:0] p_word = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (wr_req && wr_ack) begin
        chk("wr_expected", 32'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) chk("wr_word", {22'd0, wr_addr, wr_data}, 32'(exp_wr.pop_front()));
      end
      if (wr_req && p_req && !p_ack) chk("wr_stable", {22'd0, wr_addr, wr_data}, 32'(p_word));
      if (wr_req && p_req && p_ack) chk("wr_req_drop_after_ack", 1, 0);
      if (error) begin
        chk("err_single_cycle", 32'(p_err), 0);
        chk("err_expected", 32'(exp_err > 0), 1);
        if (exp_err > 0) exp_err--;
      end
    end
    p_req = wr_req; p_ack = wr_ack; p_err = error; p_word = {wr_addr, wr_data};
  end

  task automatic press(input bit e, input bit c, input bit n, input bit g, input logic [3:0] d);
    int t;
    @(negedge clk);
    es_esc = e; es_ctrl = c; es_enter = n; es_digito = g; digito = d; tecla_ok = 1'b1;
    model_key(e, c, n, g, d);
    @(posedge clk);
    #1;
    tecla_ok = 1'b0; es_esc = 0; es_ctrl = 0; es_enter = 0; es_digito = 0;
    if (m_wr_now) chk("wr_latency", 32'(wr_req), 1);
    t = 0;
    while (wr_req && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (wr_req) chk("wr_ack_wait_bound", 1, 0);
    chk("campo", 32'(campo), 32'(m_field));
    chk("ocupado", 32'(ocupado), 32'(m_act));
  endtask

  task automatic dig(input logic [3:0] d); press(0, 0, 0, 1, d); endtask
  task automatic ctrl(); press(0, 1, 0, 0, 4'd0); endtask
  task automatic enter(); press(0, 0, 1, 0, 4'd0); endtask
  task automatic esc(); press(1, 0, 0, 0, 4'd0); endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_req"}, 32'(wr_req), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_campo"}, 32'(campo), 0);
    chk({tag, "_ocupado"}, 32'(ocupado), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int k;
    int first;
    #23;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single field with a short ack delay.
    ack_tied = 0; ack_delay = 3;
    ctrl(); dig(1); dig(4); enter();
    esc();

    // Full session with ack tied high.
    ack_tied = 1;
    ctrl(); dig(2); dig(3); enter(); dig(5); dig(9); enter(); dig(0); dig(7); enter();

    // Range rejection, retry, then shift-overwrite in CONF.
    ctrl(); dig(2); dig(4); enter();
    dig(0); dig(9); enter();
    dig(1); dig(2); dig(3); enter();
    esc();

    // Delayed ack with Esc arriving mid-write.
    ack_tied = 0; ack_delay = 5;
    ctrl(); dig(1); dig(0);
    @(negedge clk);
    es_enter = 1; tecla_ok = 1;
    model_key(0, 0, 1, 0, 4'd0);
    @(posedge clk);
    #1;
    es_enter = 0; tecla_ok = 0;
    chk("delayed_wr_latency", 32'(wr_req), 1);
    @(negedge clk);
    es_esc = 1; tecla_ok = 1;
    @(posedge clk);
    #1;
    es_esc = 0; tecla_ok = 0;
    chk("esc_ignored_req", 32'(wr_req), 1);
    chk("esc_ignored_busy", 32'(ocupado), 1);
    t = 0;
    while (wr_req && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("ack_wait_len", 32'(1 + t), 5);
    chk("after_wait_campo", 32'(campo), 1);
    esc();

    // Randomised sessions, including overlapping class bits.
    for (int i = 0; i < 400; i++) begin
      int r;
      bit e, c, n, g;
      if (i % 50 == 0) begin
        ack_tied = bit'($urandom_range(0, 1));
        ack_delay = $urandom_range(1, 4);
      end
      r = $urandom_range(0, 9);
      e = (r == 0); c = (r == 1); n = (r == 2 || r == 3); g = (r >= 4);
      if ($urandom_range(0, 7) == 0) begin
        e = e | bit'($urandom_range(0, 1));
        c = c | bit'($urandom_range(0, 1));
        n = n | bit'($urandom_range(0, 1));
        g = g | bit'($urandom_range(0, 1));
      end
      press(e, c, n, g, 4'($urandom_range(0, 9)));
    end
    esc();

    // Inactivity timeout.
    ack_tied = 1;
    ctrl(); dig(5);
    exp_err++;
    model_reset();
    first = 0;
    for (k = 1; k <= 120 && first == 0; k++) begin
      @(posedge clk);
      #1;
      if (error) first = k;
    end
    chk("timeout_edge", 32'(first), 99);
    chk("timeout_idle", 32'(ocupado), 0);
    chk("timeout_campo", 32'(campo), 0);

    // Asynchronous reset while a write is outstanding.
    ack_tied = 0; ack_delay = 30;
    ctrl(); dig(1); dig(2);
    @(negedge clk);
    es_enter = 1; tecla_ok = 1;
    model_key(0, 0, 1, 0, 4'd0);
    @(posedge clk);
    #1;
    es_enter = 0; tecla_ok = 0;
    chk("pre_reset_wr_req", 32'(wr_req), 1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    exp_wr.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_wr_req", 32'(wr_req), 0);

    repeat (3) @(posedge clk);
    chk("wr_queue_empty", 32'(exp_wr.size()), 0);
    chk("err_queue_empty", 32'(exp_err), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_prog_campos.md
Name: ps2_prog_campos

Overview:
- Sequences keyboard-driven programming of the time register bank (hours, minutes, seconds).
- Consumes classified key events from the PS/2 scancode decoder and assembles two BCD digits per field.
- Range-checks each field, then writes it to the shared register bank through a request/acknowledge handshake, because the RTC updater also owns that bank.
- Sits between the PS/2 decoder and the register-bank arbiter.

Parameters:
- TIMEOUT_CYC, 50_000_000, idle cycles in any non-IDLE state before the session aborts (counter width 26 bits).
- MAX_HORA, 8'h23, maximum BCD value accepted for field 0.
- MAX_MINSEG, 8'h59, maximum BCD value accepted for fields 1 and 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- tecla_ok  input  1  one-cycle strobe; the class inputs below are valid this cycle.
- es_ctrl  input  1  key is Ctrl.
- es_enter  input  1  key is Enter.
- es_esc  input  1  key is Esc.
- es_digito  input  1  key is 0-9.
- digito  input  4  digit value, valid when es_digito.
- wr_ack  input  1  bank arbiter accepted the write this cycle.
- wr_req  output  1  write request, held until wr_ack.
- wr_addr  output  2  field index: 0 hours, 1 minutes, 2 seconds.
- wr_data  output  8  packed BCD {tens, units}.
- campo  output  2  field currently being edited.
- ocupado  output  1  high in every state except IDLE.
- error  output  1  one-cycle pulse on a rejected value or a timeout.

Behaviour:
- Reset (rst=0): state IDLE; wr_req=0, wr_addr=0, wr_data=0, campo=0, ocupado=0, error=0; digit registers and timeout counter cleared. Asynchronous reset mid-write drops wr_req immediately; no partial write is retried.
- Key events are consumed only on cycles with tecla_ok=1. If several class bits are set in one cycle, priority is esc > ctrl > enter > digito.
- Esc in any state except IDLE: return to IDLE, campo=0, no error pulse. While wr_req is high, Esc is ignored until wr_ack.
- State machine (registered state, combinational next-state):
  - IDLE: Ctrl -> DEC (campo=0).
  - DEC (tens digit): digit -> store tens, go to UNI. Enter, Ctrl: ignored.
  - UNI (units digit): digit -> store units, go to CONF.
  - CONF: Enter -> range check on {tens, units}.
    - Units must be <=9 (guaranteed by source).
    - Field 0 limit is MAX_HORA; fields 1-2 limit is MAX_MINSEG; compare as 8-bit packed BCD.
    - Pass -> ESCR. Fail -> error pulse, clear digits, go to DEC, same campo.
    - A digit in CONF overwrites: the old units become tens, the new digit becomes units, stay in CONF.
  - ESCR: wr_req=1 with wr_addr=campo and wr_data={tens, units}, all stable until wr_ack.
    - On the wr_ack cycle, wr_req falls next edge.
    - If campo==2: go to IDLE, campo=0. Otherwise campo+1, go to DEC.
- Latency: write request asserted the cycle after the accepted Enter. With wr_ack tied high, wr_req is exactly one cycle wide.
- Timeout counter:
  - Clears on every tecla_ok and on every state change; holds in ESCR.
  - Otherwise increments in non-IDLE states.
  - On reaching TIMEOUT_CYC-1: error pulse, go to IDLE, campo=0, digits cleared. A completed write already in the bank remains.
- error is registered and never wider than one cycle.
- ocupado = (state != IDLE), registered alongside the state.

Test Plan:
- Reset, then Ctrl, 1, 4, Enter -> wr_req=1, wr_addr=0, wr_data=8'h14; ack -> campo=1, state DEC.
- Full session Ctrl, 2,3,Enter, 5,9,Enter, 0,7,Enter with wr_ack tied high -> writes (0,8'h23), (1,8'h59), (2,8'h07), each wr_req one cycle wide; then IDLE, ocupado=0.
- Field 0 entry 2,4,Enter -> error pulse for one cycle, no wr_req, campo stays 0; then 0,9,Enter -> write 8'h09.
- In CONF enter digits 1,2,3 then Enter on field 1 -> write 8'h23 (shift-overwrite).
- wr_ack delayed 5 cycles with Esc injected during the wait -> wr_req and wr_data stable for 5 cycles, Esc ignored, write completes; a later Esc in DEC -> IDLE, no error.
- TIMEOUT_CYC=100 after Ctrl,5 with no further keys -> error pulse at the 100th idle cycle, IDLE. Separately, rst=0 asserted while wr_req=1 -> all outputs 0 asynchronously.
